// File: rtl/matvec_job_arbiter.sv
// Round-robin, job-locked sharing of one matvec3 engine between two valid/ready clients.
// Define MATVEC_ARB_STATS_EN to add per-client completed-job counters (job_cnt0/job_cnt1).
module matvec_job_arbiter #(
  parameter int WIDTH_IN  = 14,
  parameter int WIDTH_OUT = 28,
  parameter int IN_WORDS  = 12,
  parameter int OUT_WORDS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c0_in_valid,
  output logic                 c0_in_ready,
  input  logic [WIDTH_IN-1:0]  c0_in_data,
  input  logic                 c1_in_valid,
  output logic                 c1_in_ready,
  input  logic [WIDTH_IN-1:0]  c1_in_data,
  output logic                 c0_out_valid,
  input  logic                 c0_out_ready,
  output logic [WIDTH_OUT-1:0] c0_out_data,
  output logic                 c1_out_valid,
  input  logic                 c1_out_ready,
  output logic [WIDTH_OUT-1:0] c1_out_data,
  output logic                 eng_in_valid,
  input  logic                 eng_in_ready,
  output logic [WIDTH_IN-1:0]  eng_in_data,
  input  logic                 eng_out_valid,
  output logic                 eng_out_ready,
  input  logic [WIDTH_OUT-1:0] eng_out_data,
  output logic                 grant,
  output logic                 busy
`ifdef MATVEC_ARB_STATS_EN
  ,
  output logic [15:0]          job_cnt0,
  output logic [15:0]          job_cnt1
`endif
);

  localparam int IN_CW  = (IN_WORDS  > 1) ? $clog2(IN_WORDS)  : 1;
  localparam int OUT_CW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [IN_CW-1:0]  in_cnt_q, in_cnt_d;
  logic [OUT_CW-1:0] out_cnt_q, out_cnt_d;
  logic              last_q, last_d;
  logic              grant_q, grant_d;
  logic              in_beat, out_beat;
  logic              job_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      last_q    <= 1'b1;  // makes client0 win the first tie
      grant_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    last_d        = last_q;
    grant_d       = grant_q;
    c0_in_ready   = 1'b0;
    c1_in_ready   = 1'b0;
    eng_in_valid  = 1'b0;
    eng_in_data   = '0;
    c0_out_valid  = 1'b0;
    c1_out_valid  = 1'b0;
    c0_out_data   = '0;
    c1_out_data   = '0;
    eng_out_ready = 1'b0;
    in_beat       = 1'b0;
    out_beat      = 1'b0;
    job_done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (c0_in_valid || c1_in_valid) begin
          state_d = LOAD;
          grant_d = (c0_in_valid && c1_in_valid) ? ~last_q : c1_in_valid;
        end
      end
      LOAD: begin
        if (grant_q) begin
          eng_in_valid = c1_in_valid;
          eng_in_data  = c1_in_data;
          c1_in_ready  = eng_in_ready;
        end else begin
          eng_in_valid = c0_in_valid;
          eng_in_data  = c0_in_data;
          c0_in_ready  = eng_in_ready;
        end
        in_beat = eng_in_valid && eng_in_ready;
        if (in_beat) begin
          if (in_cnt_q == IN_CW'(IN_WORDS - 1)) begin
            in_cnt_d = '0;
            state_d  = DRAIN;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (grant_q) begin
          c1_out_valid  = eng_out_valid;
          c1_out_data   = eng_out_data;
          eng_out_ready = c1_out_ready;
        end else begin
          c0_out_valid  = eng_out_valid;
          c0_out_data   = eng_out_data;
          eng_out_ready = c0_out_ready;
        end
        out_beat = eng_out_valid && eng_out_ready;
        if (out_beat) begin
          if (out_cnt_q == OUT_CW'(OUT_WORDS - 1)) begin
            out_cnt_d = '0;
            last_d    = grant_q;
            state_d   = IDLE;
            job_done  = 1'b1;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

`ifdef MATVEC_ARB_STATS_EN
  logic [15:0] job_cnt0_q, job_cnt0_d;
  logic [15:0] job_cnt1_q, job_cnt1_d;

  // Counters wrap naturally at 16 bits.
  always_comb begin
    job_cnt0_d = job_cnt0_q;
    job_cnt1_d = job_cnt1_q;
    if (job_done && !grant_q) job_cnt0_d = job_cnt0_q + 16'd1;
    if (job_done &&  grant_q) job_cnt1_d = job_cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      job_cnt0_q <= '0;
      job_cnt1_q <= '0;
    end else begin
      job_cnt0_q <= job_cnt0_d;
      job_cnt1_q <= job_cnt1_d;
    end
  end

  assign job_cnt0 = job_cnt0_q;
  assign job_cnt1 = job_cnt1_q;
`endif

endmodule

// File: tb/tb_matvec_job_arbiter.sv
// Scoreboard bench for matvec_job_arbiter: clients push expected dot products, a monitor
// pops them as results are handed over; a behavioural matvec3 engine sits behind the arbiter.
module tb_matvec_job_arbiter;
  localparam int WI = 14;
  localparam int WO = 28;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    in_valid = '0;
  logic [WI-1:0] in_data [2];
  logic [1:0]    out_ready = '0;
  logic          c0_in_ready, c1_in_ready, c0_out_valid, c1_out_valid;
  logic [WO-1:0] c0_out_data, c1_out_data;
  logic          eng_in_valid, eng_out_ready;
  logic          eng_in_ready = 1'b0, eng_out_valid = 1'b0;
  logic [WI-1:0] eng_in_data;
  logic [WO-1:0] eng_out_data = '0;
  logic          grant, busy;
`ifdef MATVEC_ARB_STATS_EN
  logic [15:0]   job_cnt0, job_cnt1;
`endif

  matvec_job_arbiter dut (
    .clk(clk), .reset(reset),
    .c0_in_valid(in_valid[0]), .c0_in_ready(c0_in_ready), .c0_in_data(in_data[0]),
    .c1_in_valid(in_valid[1]), .c1_in_ready(c1_in_ready), .c1_in_data(in_data[1]),
    .c0_out_valid(c0_out_valid), .c0_out_ready(out_ready[0]), .c0_out_data(c0_out_data),
    .c1_out_valid(c1_out_valid), .c1_out_ready(out_ready[1]), .c1_out_data(c1_out_data),
    .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready), .eng_in_data(eng_in_data),
    .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready), .eng_out_data(eng_out_data),
    .grant(grant), .busy(busy)
`ifdef MATVEC_ARB_STATS_EN
    , .job_cnt0(job_cnt0), .job_cnt1(job_cnt1)
`endif
  );

  int checks = 0;
  int passed = 0;
  logic [WO-1:0] exp0[$], exp1[$];
  int  taken[2];
  int  grant_log[$], gap_log[$];
  bit  force_low[2];
  bit  rnd_ready = 1'b1;
  bit  busy_prev = 1'b0;
  int  idle_run = 0;
  logic [WI-1:0] wa[12], wb[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Row r of the 3x3 row-major matrix dotted with the vector in words 9..11.
  function automatic logic [WO-1:0] dot(input logic [WI-1:0] w[12], input int r);
    logic [WO-1:0] s = '0;
    for (int j = 0; j < 3; j++) s += WO'(w[3*r+j]) * WO'(w[9+j]);
    return s;
  endfunction

  // Behavioural engine: collect 12 words, then offer 3 results, with random stalls.
  initial begin
    int e_in = 0, e_out = 0;
    logic [WI-1:0] e_w[12];
    logic [WO-1:0] e_res[3];
    bit in_fire, out_fire, rst_s;
    logic [WI-1:0] din;
    forever begin
      @(negedge clk);
      in_fire  = eng_in_valid && eng_in_ready;
      out_fire = eng_out_valid && eng_out_ready;
      din      = eng_in_data;
      rst_s    = reset;
      @(posedge clk); #1;
      if (rst_s) begin
        e_in = 0; e_out = 0;
      end else begin
        if (in_fire && e_in < 12) begin
          e_w[e_in] = din;
          e_in++;
          if (e_in == 12) begin
            for (int r = 0; r < 3; r++) e_res[r] = dot(e_w, r);
            e_out = 0;
          end
        end
        if (out_fire) begin
          e_out++;
          if (e_out == 3) begin e_in = 0; e_out = 0; end
        end
      end
      eng_in_ready  = (e_in < 12) && ($urandom_range(0, 3) != 0);
      eng_out_valid = (e_in == 12) && ($urandom_range(0, 3) != 0);
      eng_out_data  = (e_in == 12) ? e_res[e_out] : '0;
    end
  end

  // Client result-side ready, driven late in the cycle so tests can force it low first.
  initial forever begin
    @(posedge clk); #2;
    for (int c = 0; c < 2; c++)
      out_ready[c] = force_low[c] ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  // Monitor: consume expected results, log grant order and idle gaps between jobs.
  initial forever begin
    logic [WO-1:0] e;
    @(negedge clk);
    if (reset) begin
      taken[0] = 0; taken[1] = 0; busy_prev = 1'b0; idle_run = 0;
    end else begin
      if (c0_out_valid) begin
        chk("c0_valid_expected", 64'(exp0.size() > 0), 1);
        if (out_ready[0] && exp0.size() > 0) begin
          e = exp0.pop_front();
          chk("c0_result", c0_out_data, e);
          taken[0]++;
        end
      end
      if (c1_out_valid) begin
        chk("c1_valid_expected", 64'(exp1.size() > 0), 1);
        if (out_ready[1] && exp1.size() > 0) begin
          e = exp1.pop_front();
          chk("c1_result", c1_out_data, e);
          taken[1]++;
        end
      end
      if (busy && !busy_prev) begin
        grant_log.push_back(int'(grant));
        gap_log.push_back(idle_run);
      end
      idle_run  = busy ? 0 : idle_run + 1;
      busy_prev = busy;
    end
  end

  task automatic send_job(input int c, input logic [WI-1:0] w[12], input int nbeats,
                          input int pause_at, input int pause_len);
    int  i = 0;
    int  guard = 0;
    bit  fire;
    if (nbeats == 12)
      for (int r = 0; r < 3; r++) begin
        if (c == 0) exp0.push_back(dot(w, r));
        else        exp1.push_back(dot(w, r));
      end
    @(posedge clk); #1;
    in_valid[c] = 1'b1;
    in_data[c]  = w[0];
    while (i < nbeats) begin
      @(negedge clk);
      fire = in_valid[c] && ((c == 0) ? c0_in_ready : c1_in_ready);
      @(posedge clk); #1;
      guard++;
      if (guard > 3000) begin
        chk("job_timeout", i, nbeats);
        in_valid[c] = 1'b0;
        return;
      end
      if (fire) begin
        i++;
        if (i == pause_at && i < nbeats) begin
          in_valid[c] = 1'b0;
          repeat (pause_len) begin
            @(negedge clk);
            chk("pause_no_forward", eng_in_valid, 0);
            @(posedge clk); #1;
          end
        end
      end
      if (i < nbeats) begin in_valid[c] = 1'b1; in_data[c] = w[i]; end
      else in_valid[c] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_complete", 64'(exp0.size() + exp1.size()), 0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    grant_log.delete();
    gap_log.delete();
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_hs"}, {c0_in_ready, c1_in_ready, c0_out_valid, c1_out_valid,
                       eng_in_valid, eng_out_ready}, 0);
    chk({tag, "_eng_data"}, eng_in_data, 0);
    chk({tag, "_out_data"}, c0_out_data | c1_out_data, 0);
  endtask

  task automatic rand_words(output logic [WI-1:0] w[12]);
    for (int i = 0; i < 12; i++) w[i] = WI'($urandom_range(0, 4095));
  endtask

  initial begin
    int  n;
    bit  saw_ready;
    in_data[0] = '0;
    in_data[1] = '0;
    force_low[0] = 1'b0;
    force_low[1] = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1 reset = 1'b0;

    // c0 alone: matrix 1..9, vector 10..12 -> 68, 167, 266
    for (int i = 0; i < 12; i++) wa[i] = WI'(i + 1);
    chk("ref_row0", dot(wa, 0), 68);
    chk("ref_row2", dot(wa, 2), 266);
    send_job(0, wa, 12, 0, 0);
    wait_idle();
    chk("c0_only_results_taken", taken[0], 3);

    // Simultaneous requests: c0 wins first tie; c0 re-requests while c1 waits -> c1 next
    apply_reset();
    rand_words(wa);
    rand_words(wb);
    fork
      begin send_job(0, wa, 12, 0, 0); send_job(0, wb, 12, 0, 0); end
      send_job(1, wb, 12, 0, 0);
    join
    wait_idle();
    chk("rr_job_count", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      // last starts at 1: tie -> c0; tie again with last=0 -> c1; c0 alone -> c0
      chk("rr_grant0", grant_log[0], 0);
      chk("rr_grant1", grant_log[1], 1);
      chk("rr_grant2", grant_log[2], 0);
      chk("rr_gap1", gap_log[1], 1);
      chk("rr_gap2", gap_log[2], 1);
    end

    // c1 owns; c0 keeps requesting and must see no ready until c1's third result is taken
    apply_reset();
    rand_words(wa);
    rand_words(wb);
    saw_ready = 1'b0;
    fork
      send_job(1, wb, 12, 0, 0);
      begin repeat (3) @(posedge clk); send_job(0, wa, 12, 0, 0); end
      begin
        n = 0;
        while (taken[1] < 3 && n < 3000) begin
          @(negedge clk);
          if (in_valid[0] && c0_in_ready) saw_ready = 1'b1;
          n++;
        end
        chk("c0_blocked_while_c1_owns", saw_ready, 0);
      end
    join
    wait_idle();
    chk("blocked_grant_order", grant_log.size() >= 2 ? grant_log[0] * 2 + grant_log[1] : -1, 2);

    // Input pause after beat 6 and result back-pressure in DRAIN
    apply_reset();
    rnd_ready = 1'b0;
    rand_words(wa);
    send_job(0, wa, 12, 6, 5);
    force_low[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("drain_hold_eng_out_ready", eng_out_ready, 0);
    end
    chk("drain_hold_results_kept", exp0.size(), 3);
    @(posedge clk); #1 force_low[0] = 1'b0;
    wait_idle();
    chk("hold_results_taken", taken[0], 3);

    // Reset after beat 7: job abandoned, quiet outputs, next job correct
    rnd_ready = 1'b1;
    rand_words(wa);
    send_job(0, wa, 7, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_quiet("midjob_reset");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", busy, 0);
    rand_words(wa);
    send_job(0, wa, 12, 0, 0);
    wait_idle();
    chk("post_reset_results", taken[0], 3);

    // Random concurrent traffic from both clients
    fork
      for (int k = 0; k < 6; k++) begin
        rand_words(wa);
        send_job(0, wa, 12, $urandom_range(1, 14), $urandom_range(0, 3));
        repeat ($urandom_range(0, 4)) @(posedge clk);
      end
      for (int k = 0; k < 6; k++) begin
        rand_words(wb);
        send_job(1, wb, 12, $urandom_range(1, 14), $urandom_range(0, 3));
        repeat ($urandom_range(0, 4)) @(posedge clk);
      end
    join
    wait_idle();
    chk("random_c0_results", taken[0], 21);
    chk("random_c1_results", taken[1], 18);

`ifdef MATVEC_ARB_STATS_EN
    chk("job_cnt0", job_cnt0, 64'(taken[0] / 3));
    chk("job_cnt1", job_cnt1, 64'(taken[1] / 3));
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d, expected %0d", checks, 0);
    $fatal(1, "bench did not terminate");
  end

endmodule
